bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 25 ++
 rtl/bus_arbiter.sv | 128 ++++++++++++
 tb/tb_bus_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Bus arbiter handshake bundle: DMA request/grant, CPU memory request/stall,
// and the DMA completion interrupt pair.
interface bus_arbiter_if;
    logic       BR;
    logic       dma_interrupt;
    logic       cpu_mem_req;
    logic       int_ack;
    logic       BG;
    logic       cpu_stall;
    logic       steal_active;
    logic       int_pending;
    logic [7:0] grant_count;

    // Arbiter side
    modport slave (
        input  BR, dma_interrupt, cpu_mem_req, int_ack,
        output BG, cpu_stall, steal_active, int_pending, grant_count
    );

    // System side: DMA engine and CPU
    modport master (
        output BR, dma_interrupt, cpu_mem_req, int_ack,
        input  BG, cpu_stall, steal_active, int_pending, grant_count
    );
endinterface

// File: rtl/bus_arbiter.sv
// DMA/CPU bus arbiter. The DMA owns the bus while granted; after a bounded
// hold the CPU may preempt for a short cycle-steal window, with a one-cycle
// turnaround between owners. Completion interrupts are latched until acked.
module bus_arbiter #(
    parameter int HOLD_MAX  = 5,
    parameter int STEAL_LEN = 2
) (
    input  logic         CLK,
    input  logic         reset_n,
    bus_arbiter_if.slave bus
);
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam int SW = (STEAL_LEN > 1) ? $clog2(STEAL_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DMA     = 2'd1,
        RELEASE = 2'd2,
        STEAL   = 2'd3
    } state_t;

    state_t          state_r;
    logic [HW-1:0]   hold_cnt_r;
    logic [SW-1:0]   steal_cnt_r;
    logic            steal_flag_r;
    logic            bg_r;
    logic            steal_active_r;
    logic            int_pending_r;
    logic [7:0]      grant_count_r;
    // Set once BR has been seen high on an edge after reset, so the first
    // grant cannot land on the very first BR edge following reset release.
    logic            armed_r;

    // Arbitration FSM with registered grant/steal outputs and counters
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            hold_cnt_r     <= '0;
            steal_cnt_r    <= '0;
            steal_flag_r   <= 1'b0;
            bg_r           <= 1'b0;
            steal_active_r <= 1'b0;
            grant_count_r  <= 8'd0;
            armed_r        <= 1'b0;
        end else begin
            armed_r <= armed_r | bus.BR;
            case (state_r)
                IDLE: begin
                    steal_active_r <= 1'b0;
                    if (bus.BR && armed_r) begin
                        state_r       <= DMA;
                        bg_r          <= 1'b1;
                        hold_cnt_r    <= '0;
                        grant_count_r <= grant_count_r + 8'd1;
                    end else begin
                        bg_r <= 1'b0;
                    end
                end
                DMA: begin
                    // Completion or withdrawal outranks a CPU preemption
                    if (bus.dma_interrupt || !bus.BR) begin
                        state_r      <= RELEASE;
                        steal_flag_r <= 1'b0;
                        bg_r         <= 1'b0;
                    end else if ((hold_cnt_r == HW'(HOLD_MAX - 1)) && bus.cpu_mem_req) begin
                        state_r      <= RELEASE;
                        steal_flag_r <= 1'b1;
                        bg_r         <= 1'b0;
                    end else begin
                        bg_r <= 1'b1;
                        if (hold_cnt_r != HW'(HOLD_MAX)) begin
                            hold_cnt_r <= hold_cnt_r + HW'(1);
                        end else begin
                            hold_cnt_r <= hold_cnt_r;
                        end
                    end
                end
                RELEASE: begin
                    bg_r <= 1'b0;
                    if (steal_flag_r) begin
                        state_r        <= STEAL;
                        steal_cnt_r    <= '0;
                        steal_active_r <= 1'b1;
                    end else begin
                        state_r        <= IDLE;
                        steal_active_r <= 1'b0;
                    end
                end
                STEAL: begin
                    bg_r <= 1'b0;
                    if ((steal_cnt_r == SW'(STEAL_LEN - 1)) || !bus.cpu_mem_req) begin
                        state_r        <= IDLE;
                        steal_flag_r   <= 1'b0;
                        steal_active_r <= 1'b0;
                    end else begin
                        steal_cnt_r    <= steal_cnt_r + SW'(1);
                        steal_active_r <= 1'b1;
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    bg_r           <= 1'b0;
                    steal_active_r <= 1'b0;
                end
            endcase
        end
    end

    // Completion interrupt latch; a new completion beats a simultaneous ack
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            int_pending_r <= 1'b0;
        end else if (bus.dma_interrupt) begin
            int_pending_r <= 1'b1;
        end else if (bus.int_ack) begin
            int_pending_r <= 1'b0;
        end else begin
            int_pending_r <= int_pending_r;
        end
    end

    // The CPU freezes only while the DMA owns the bus or it is turning around
    assign bus.cpu_stall    = bus.cpu_mem_req & ((state_r == DMA) | (state_r == RELEASE));
    assign bus.BG           = bg_r;
    assign bus.steal_active = steal_active_r;
    assign bus.int_pending  = int_pending_r;
    assign bus.grant_count  = grant_count_r;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: each step pushes the expected outputs for
// that cycle into a scoreboard, drives the inputs, and compares mid-cycle.
module tb_bus_arbiter;
    logic CLK = 1'b0;
    logic reset_n;

    always #5 CLK = ~CLK;

    bus_arbiter_if bus();

    bus_arbiter #(.HOLD_MAX(5), .STEAL_LEN(2)) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic       bg;
        logic       stall;
        logic       steal;
        logic       intp;
        logic [7:0] gc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input logic bg, input logic stall, input logic steal,
                        input logic intp, input logic [7:0] gc);
        exp_t e;
        e.bg = bg; e.stall = stall; e.steal = steal; e.intp = intp; e.gc = gc;
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t o;
        exp_t e;
        o.bg    = bus.BG;
        o.stall = bus.cpu_stall;
        o.steal = bus.steal_active;
        o.intp  = bus.int_pending;
        o.gc    = bus.grant_count;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, o);
        end else begin
            e = exp_q.pop_front();
            assert (o === e) else begin
                errors++;
                $error("FAIL %s: observed BG=%b stall=%b steal=%b intp=%b gc=%0d, expected BG=%b stall=%b steal=%b intp=%b gc=%0d",
                       tag, o.bg, o.stall, o.steal, o.intp, o.gc,
                       e.bg, e.stall, e.steal, e.intp, e.gc);
            end
        end
    endtask

    // One clock cycle: expected outputs, inputs (br, irq, req, ack), compare
    task automatic step(input logic br, input logic irq, input logic req, input logic ack,
                        input logic bg, input logic stall, input logic steal,
                        input logic intp, input logic [7:0] gc, input string tag);
        push(bg, stall, steal, intp, gc);
        @(negedge CLK);
        bus.BR            = br;
        bus.dma_interrupt = irq;
        bus.cpu_mem_req   = req;
        bus.int_ack       = ack;
        #1;
        check(tag);
    endtask

    initial begin
        reset_n           = 1'b0;
        bus.BR            = 1'b0;
        bus.dma_interrupt = 1'b0;
        bus.cpu_mem_req   = 1'b0;
        bus.int_ack       = 1'b0;

        // Reset state, request ignored while in reset
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "reset_br");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "reset_idle");
        reset_n = 1'b1;

        // Constant BR and CPU demand: 5 DMA, 1 release, 2 steal, 1 idle
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "arm");
        for (int p = 0; p < 2; p++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'(p), "idle");
            for (int k = 0; k < 5; k++)
                step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'(p + 1), "dma_hold");
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'(p + 1), "release");
            for (int k = 0; k < 2; k++)
                step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'(p + 1), "steal");
        end

        // CPU demand drops in the first steal cycle: single-cycle steal
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, "idle3");
        for (int k = 0; k < 5; k++)
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3, "dma_hold3");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, "release3");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, "steal_short");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, "idle_after_short");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4, "regrant_br_drop");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, "release_no_steal");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, "idle_quiet");

        // No CPU demand at the preempt point: DMA keeps the bus; late demand
        // after the hold counter saturates only stalls; completion releases
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, "idle5");
        for (int k = 0; k < 5; k++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5, "dma_no_req");
        for (int k = 0; k < 5; k++)
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5, "dma_saturated");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5, "dma_irq");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5, "release_irq");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5, "idle_irq");

        // Interrupt latch: ack clears, set wins over simultaneous ack
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5, "ack_clear");
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5, "irq_and_ack");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5, "set_wins");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5, "ack_alone");

        // Asynchronous reset between edges while granted
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5, "idle_pre_rst");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd6, "dma_pre_rst");
        #2;
        reset_n = 1'b0;
        #1;
        push(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        check("async_rst");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "rst_held");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "rst_held2");
        reset_n = 1'b1;

        // First BR edge after reset only arms; then 256 grants wrap the count
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "first_br_edge");
        for (int i = 1; i <= 256; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'(i - 1), "wrap_idle");
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(i), "wrap_dma");
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'(i), "wrap_release");
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "wrap_zero");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
